lane_order_arbiter: RTL and testbench
=====================================

# lane_order_arbiter

Controller that shares the 2-bit ordered output register between two 1-bit requesters, lane 1 and lane 2. It accepts one bit from each lane over valid/ready handshakes and pairs them. It drives the 2-bit register with a round-robin lane order, then presents the pair downstream under a valid/ready handshake. It sits between the two serial data sources and the ordered-pair consumer, and it owns the `order` decision that the register previously took as a raw input.

## Interface
- `TIMEOUT`, 8: cycles spent waiting for the missing lane before a partial pair is emitted; legal range 1..255.
- `COUNT_W`, 8: width of `pair_count`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `data1_valid`  in  1  lane-1 bit offered.
- `data1`  in  1  lane-1 bit.
- `data1_ready`  out  1  lane-1 bit accepted this cycle when high together with `data1_valid`.
- `data2_valid`  in  1  lane-2 bit offered.
- `data2`  in  1  lane-2 bit.
- `data2_ready`  out  1  lane-2 accept.
- `out`  out  2  registered ordered pair.
- `out_valid`  out  1  `out` holds a complete or partial pair.
- `out_ready`  in  1  downstream accepts `out`.
- `order`  out  1  ordering that applies to the current or next pair.
- `partial`  out  1  current pair was closed by timeout; the missing lane bit is 0.
- `pair_count`  out  COUNT_W  number of pairs handed off, wraps.

## Operation
- State machine states: IDLE (nothing captured), HAVE1 (lane 1 captured), HAVE2 (lane 2 captured), FULL (pair ready, `out_valid`=1).
- `data1_ready` = 1 in IDLE and HAVE2. `data2_ready` = 1 in IDLE and HAVE1. Both readies are 0 in FULL.
- Placement: with `order`=0, lane 1 → `out[1]` and lane 2 → `out[0]`. With `order`=1, lane 1 → `out[0]` and lane 2 → `out[1]`.
- IDLE transitions:
  - both valid → FULL.
  - only lane 1 valid → HAVE1.
  - only lane 2 valid → HAVE2.
  - neither → stay in IDLE.
- HAVE1 or HAVE2: when the partner lane's valid is seen → FULL with `partial`=0.
- FULL: on `out_valid`&`out_ready` → IDLE. In the same edge, `order` toggles, `pair_count` increments modulo 2^COUNT_W, and `partial` clears.
- `out` holds its bits until the next capture overwrites them. Each bit is written at the edge its lane is captured.
- Reset values: state IDLE, `out`=2'b00, `out_valid`=0, `order`=0, `partial`=0, `pair_count`=0, both readies 0 during the reset cycle, wait counter 0.
- Reset mid-operation: any captured bits and any pending pair are discarded, with no handoff and no count.

## Timing
- Capture happens at the edge where valid and ready are both 1. `out_valid` rises on the edge that completes the pair, so it is visible the cycle after the second capture. When both lanes arrive together, `out_valid` is visible 1 cycle after they arrive.
- Throughput: one pair per 2 cycles minimum, since FULL accepts no new input. Back-to-back operation alternates FULL and capture cycles.
- Simultaneous lane arrival in IDLE: both bits are captured in one cycle with the same `order`.
- `out_ready` held low: FULL persists indefinitely, and all outputs stay stable.
- `pair_count` wraps from all-ones to 0 with no flag.

## Configuration
- Macro `LANE_TIMEOUT_EN`, defined:
  - In HAVE1/HAVE2, the wait counter increments each cycle, starting from 0 on entry.
  - When the counter equals TIMEOUT−1 and the partner is not valid, the next edge enters FULL with `partial`=1 and the missing bit forced to 0.
  - The missing lane's ready is 0 from that point.
  - If the partner is valid in the same cycle, a normal capture wins and `partial`=0.
- Not defined: there is no counter. HAVE1/HAVE2 wait indefinitely, and `partial` is tied to 0.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → `out`=00, `out_valid`=0, `order`=0, `pair_count`=0.
- Simultaneous arrival: with `order`=0, drive `data1`=1 and `data2`=0 together → next cycle `out`=2'b10, `out_valid`=1. Accept the pair → `order`=1, `pair_count`=1.
- Staggered arrival after the toggle: lane 1 sends 1, then lane 2 sends 0 three cycles later → `out`=2'b01, `out_valid`=1, and `data1_ready`=0 while waiting. Accept → `order`=0, `pair_count`=2.
- Backpressure: keep `out_ready`=0 for 10 cycles in FULL → `out` stable and both readies 0. Lanes holding valid are not accepted until the handoff.
- Timeout, with `LANE_TIMEOUT_EN` and TIMEOUT=4: lane 2 sends 1 alone, lane 1 stays silent → after the 4 HAVE2 cycles, `out_valid`=1 with `partial`=1 and `out`=2'b01 (order 0). Rerun with lane 1 arriving in the 4th cycle → `partial`=0.
- Reset mid-operation: capture lane 1, assert `reset`=0 for one cycle → IDLE, `out`=00. A later single lane-2 bit produces no `out_valid` without its partner (macro off).

Source files
------------

// File: rtl/lane_order_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lane_order_arbiter_if
// Purpose  : Bundle of the two lane handshakes and the ordered-pair output
//            handshake of lane_order_arbiter.
// Signals  : data1_valid/data1/data1_ready  lane-1 serial bit handshake
//            data2_valid/data2/data2_ready  lane-2 serial bit handshake
//            out/out_valid/out_ready        ordered pair to the consumer
//            order                          lane order for current/next pair
//            partial                        pair closed by timeout
//            pair_count                     pairs handed off (wraps)
// Modports : slave  - the arbiter side
//            master - the sources/consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface lane_order_arbiter_if #(
    parameter int COUNT_W = 8
);
    logic               data1_valid;
    logic               data1;
    logic               data1_ready;
    logic               data2_valid;
    logic               data2;
    logic               data2_ready;
    logic [1:0]         out;
    logic               out_valid;
    logic               out_ready;
    logic               order;
    logic               partial;
    logic [COUNT_W-1:0] pair_count;

    modport slave (
        input  data1_valid, data1, data2_valid, data2, out_ready,
        output data1_ready, data2_ready, out, out_valid, order, partial, pair_count
    );

    modport master (
        output data1_valid, data1, data2_valid, data2, out_ready,
        input  data1_ready, data2_ready, out, out_valid, order, partial, pair_count
    );
endinterface
`default_nettype wire

// File: rtl/lane_order_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lane_order_arbiter
// Purpose  : Pairs one bit from lane 1 with one bit from lane 2 into a 2-bit
//            ordered register, alternating the lane order after every
//            handoff, and presents the pair under a valid/ready handshake.
// Ports    : clk    - rising-edge clock
//            reset  - synchronous active-low reset
//            bus    - lane_order_arbiter_if.slave (lane inputs, pair output)
// Params   : TIMEOUT (1..255) - wait cycles before a partial pair is closed
//            COUNT_W          - width of pair_count
// Options  : LANE_TIMEOUT_EN - when defined, a lone captured lane waits at
//            most TIMEOUT cycles for its partner, then the pair is closed
//            with the missing bit forced to 0 and partial set.
// Revision : 1.0 - initial release
// ============================================================================
module lane_order_arbiter #(
    parameter int TIMEOUT = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    lane_order_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HAVE1 = 2'd1,
        S_HAVE2 = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("lane_order_arbiter: TIMEOUT must be in 1..255");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [1:0]         out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               order_q, order_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic               w_rdy1, w_rdy2;
    logic               w_cap1, w_cap2;

`ifdef LANE_TIMEOUT_EN
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);
    logic               partial_q, partial_d;
    logic [7:0]         wait_q, wait_d;
`endif

    // Readies are a decode of the state, forced low while reset is held so
    // no bit is taken during the reset cycle.
    assign w_rdy1 = reset && (state_q == S_IDLE || state_q == S_HAVE2);
    assign w_rdy2 = reset && (state_q == S_IDLE || state_q == S_HAVE1);
    assign w_cap1 = w_rdy1 && bus.data1_valid;
    assign w_cap2 = w_rdy2 && bus.data2_valid;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        order_d     = order_q;
        cnt_d       = cnt_q;
`ifdef LANE_TIMEOUT_EN
        partial_d   = partial_q;
        wait_d      = 8'd0;
`endif

        // Each lane bit lands at the edge it is captured. order=0 puts lane 1
        // in the high bit, order=1 puts it in the low bit.
        if (w_cap1) begin
            if (order_q) out_d[0] = bus.data1;
            else         out_d[1] = bus.data1;
        end
        if (w_cap2) begin
            if (order_q) out_d[1] = bus.data2;
            else         out_d[0] = bus.data2;
        end

        case (state_q)
            S_IDLE: begin
                if (w_cap1 && w_cap2) state_d = S_FULL;
                else if (w_cap1)      state_d = S_HAVE1;
                else if (w_cap2)      state_d = S_HAVE2;
            end
            S_HAVE1: begin
                if (w_cap2) begin
                    state_d = S_FULL;
                end
`ifdef LANE_TIMEOUT_EN
                else if (wait_q == C_TO_LAST) begin
                    // Close the pair with lane 2's slot zeroed.
                    if (order_q) out_d[1] = 1'b0;
                    else         out_d[0] = 1'b0;
                    partial_d = 1'b1;
                    state_d   = S_FULL;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            S_HAVE2: begin
                if (w_cap1) begin
                    state_d = S_FULL;
                end
`ifdef LANE_TIMEOUT_EN
                else if (wait_q == C_TO_LAST) begin
                    if (order_q) out_d[0] = 1'b0;
                    else         out_d[1] = 1'b0;
                    partial_d = 1'b1;
                    state_d   = S_FULL;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            S_FULL: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    order_d = ~order_q;
                    cnt_d   = cnt_q + COUNT_W'(1);
`ifdef LANE_TIMEOUT_EN
                    partial_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_valid_d = (state_d == S_FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            out_q       <= 2'b00;
            out_valid_q <= 1'b0;
            order_q     <= 1'b0;
            cnt_q       <= '0;
`ifdef LANE_TIMEOUT_EN
            partial_q   <= 1'b0;
            wait_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            order_q     <= order_d;
            cnt_q       <= cnt_d;
`ifdef LANE_TIMEOUT_EN
            partial_q   <= partial_d;
            wait_q      <= wait_d;
`endif
        end
    end

    assign bus.data1_ready = w_rdy1;
    assign bus.data2_ready = w_rdy2;
    assign bus.out         = out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.order       = order_q;
    assign bus.pair_count  = cnt_q;
`ifdef LANE_TIMEOUT_EN
    assign bus.partial     = partial_q;
`else
    assign bus.partial     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lane_order_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_order_arbiter
// Purpose  : Self-checking bench for lane_order_arbiter. A behavioural pair
//            model tracks which lane bits are held and checks every output
//            on each falling edge; directed steps add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_order_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lane_order_arbiter_if #(.COUNT_W(8)) bus();

    lane_order_arbiter #(.TIMEOUT(TO), .COUNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    bit         m_h1, m_h2, m_v, m_p, m_ord;
    logic [1:0] m_out;
    logic [7:0] m_cnt;
    int         m_wait;

    task automatic model_step();
        bit c1, c2, single;
        if (!reset) begin
            m_h1 = 0; m_h2 = 0; m_v = 0; m_p = 0; m_ord = 0;
            m_out = 2'b00; m_cnt = 8'd0; m_wait = 0;
        end else if (m_v) begin
            if (bus.out_ready) begin
                m_v = 0; m_h1 = 0; m_h2 = 0; m_p = 0;
                m_ord = !m_ord;
                m_cnt = m_cnt + 8'd1;
            end
        end else begin
            single = m_h1 ^ m_h2;
            c1 = !m_h1 && bus.data1_valid;
            c2 = !m_h2 && bus.data2_valid;
            if (c1) begin m_out[m_ord ? 0 : 1] = bus.data1; m_h1 = 1; end
            if (c2) begin m_out[m_ord ? 1 : 0] = bus.data2; m_h2 = 1; end
            if (m_h1 && m_h2) begin
                m_v = 1;
            end else if (single) begin
`ifdef LANE_TIMEOUT_EN
                if (m_wait == TO - 1) begin
                    if (!m_h1) m_out[m_ord ? 0 : 1] = 1'b0;
                    else       m_out[m_ord ? 1 : 0] = 1'b0;
                    m_v = 1; m_p = 1;
                end else begin
                    m_wait = m_wait + 1;
                end
`endif
            end
            if (!single) m_wait = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model-vs-DUT check on every falling edge.
    initial forever begin
        @(negedge clk);
        cmp("model.rdy1", {31'd0, bus.data1_ready}, {31'd0, reset && !m_v && !m_h1});
        cmp("model.rdy2", {31'd0, bus.data2_ready}, {31'd0, reset && !m_v && !m_h2});
        cmp("model.out", {30'd0, bus.out}, {30'd0, m_out});
        cmp("model.out_valid", {31'd0, bus.out_valid}, {31'd0, m_v});
        cmp("model.order", {31'd0, bus.order}, {31'd0, m_ord});
        cmp("model.partial", {31'd0, bus.partial}, {31'd0, m_p});
        cmp("model.pair_count", {24'd0, bus.pair_count}, {24'd0, m_cnt});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp(name, act, exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0;
        bus.data1_valid = 0; bus.data1 = 0;
        bus.data2_valid = 0; bus.data2 = 0;
        bus.out_ready   = 0;

        // Reset held two cycles
        tick(); tick();
        lit("rst.out", {30'd0, bus.out}, 32'd0);
        lit("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        lit("rst.order", {31'd0, bus.order}, 32'd0);
        lit("rst.pair_count", {24'd0, bus.pair_count}, 32'd0);
        lit("rst.readies", {30'd0, bus.data1_ready, bus.data2_ready}, 32'd0);
        reset = 1'b1;
        tick();

        // Simultaneous arrival, order 0: lane1=1 -> out[1], lane2=0 -> out[0]
        bus.data1_valid = 1; bus.data1 = 1;
        bus.data2_valid = 1; bus.data2 = 0;
        tick();
        bus.data1_valid = 0; bus.data2_valid = 0;
        lit("simul.out", {30'd0, bus.out}, 32'h2);
        lit("simul.out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        lit("simul.order", {31'd0, bus.order}, 32'd1);
        lit("simul.count", {24'd0, bus.pair_count}, 32'd1);

        // Staggered arrival with order 1
        bus.data1_valid = 1; bus.data1 = 1;
        tick();
        bus.data1_valid = 0;
        lit("stag.rdy1_wait", {31'd0, bus.data1_ready}, 32'd0);
        tick(); tick();
        lit("stag.no_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.data2_valid = 1; bus.data2 = 0;
        tick();
        bus.data2_valid = 0;
        lit("stag.out", {30'd0, bus.out}, 32'h1);
        lit("stag.out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        lit("stag.order", {31'd0, bus.order}, 32'd0);
        lit("stag.count", {24'd0, bus.pair_count}, 32'd2);

        // Backpressure: pair 01 held while lanes keep offering
        bus.data1_valid = 1; bus.data1 = 0;
        bus.data2_valid = 1; bus.data2 = 1;
        tick();
        bus.data1 = 1; bus.data2 = 1;
        for (int i = 0; i < 10; i++) begin
            lit("bp.out", {30'd0, bus.out}, 32'h1);
            lit("bp.readies", {30'd0, bus.data1_ready, bus.data2_ready}, 32'd0);
            tick();
        end
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        lit("bp.handoff_count", {24'd0, bus.pair_count}, 32'd3);
        lit("bp.handoff_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        bus.data1_valid = 0; bus.data2_valid = 0;
        lit("bp.next_out", {30'd0, bus.out}, 32'h3);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        lit("bp.order", {31'd0, bus.order}, 32'd0);

`ifdef LANE_TIMEOUT_EN
        // Timeout: lane 2 alone, order 0 -> out 01 partial
        bus.data2_valid = 1; bus.data2 = 1;
        tick();
        bus.data2_valid = 0;
        tick(); tick(); tick();
        lit("to.not_yet", {31'd0, bus.out_valid}, 32'd0);
        tick();
        lit("to.valid", {31'd0, bus.out_valid}, 32'd1);
        lit("to.partial", {31'd0, bus.partial}, 32'd1);
        lit("to.out", {30'd0, bus.out}, 32'h1);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        lit("to.partial_clr", {31'd0, bus.partial}, 32'd0);
        // Partner arrives in the last waiting cycle (order 1)
        bus.data2_valid = 1; bus.data2 = 1;
        tick();
        bus.data2_valid = 0;
        tick(); tick(); tick();
        bus.data1_valid = 1; bus.data1 = 0;
        tick();
        bus.data1_valid = 0;
        lit("to2.valid", {31'd0, bus.out_valid}, 32'd1);
        lit("to2.partial", {31'd0, bus.partial}, 32'd0);
        lit("to2.out", {30'd0, bus.out}, 32'h2);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
`endif

        // Reset mid-operation discards the captured lane-1 bit
        bus.data1_valid = 1; bus.data1 = 1;
        tick();
        bus.data1_valid = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        lit("midrst.out", {30'd0, bus.out}, 32'd0);
        lit("midrst.valid", {31'd0, bus.out_valid}, 32'd0);
        lit("midrst.count", {24'd0, bus.pair_count}, 32'd0);
        bus.data2_valid = 1; bus.data2 = 1;
        tick();
        bus.data2_valid = 0;
        for (int i = 0; i < 6; i++) tick();
`ifdef LANE_TIMEOUT_EN
        lit("midrst.lone_lane2", {31'd0, bus.out_valid}, 32'd1);
`else
        lit("midrst.lone_lane2", {31'd0, bus.out_valid}, 32'd0);
`endif
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Back-to-back throughput and pair_count wrap
        bus.data1_valid = 1; bus.data2_valid = 1; bus.out_ready = 1;
        for (int i = 0; i < 512; i++) begin
            bus.data1 = 1'($urandom_range(0, 1));
            bus.data2 = 1'($urandom_range(0, 1));
            tick();
            if (i == 509) lit("wrap.count_ff", {24'd0, bus.pair_count}, 32'd255);
        end
        lit("wrap.count_0", {24'd0, bus.pair_count}, 32'd0);
        bus.data1_valid = 0; bus.data2_valid = 0; bus.out_ready = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
